fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline. It is the producer side of the decode stage's Instr/IncPC interface.
- Holds the PC and issues reads to a variable-latency instruction memory using a request/done handshake.
- Registers each fetched instruction and its PC+2 toward decode.
- Absorbs decode stalls with a one-entry buffer, handles branch/jump redirects, including redirects while a read is outstanding, and stops fetching on HALT.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory read port, decode-side
// Instr/IncPC handshake and downstream redirect/halt controls.
interface fetch_unit_if;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        Halt;
  logic [15:0] IMemAddr;
  logic        IMemRd;
  logic [15:0] IMemData;
  logic        IMemDone;
  logic [15:0] Instr;
  logic [15:0] IncPC;
  logic        InstrValid;
  logic        Err;

  modport master (
    input  Stall, Redirect, RedirectPC, Halt, IMemData, IMemDone,
    output IMemAddr, IMemRd, Instr, IncPC, InstrValid, Err
  );

  modport slave (
    output Stall, Redirect, RedirectPC, Halt, IMemData, IMemDone,
    input  IMemAddr, IMemRd, Instr, IncPC, InstrValid, Err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC/request register, variable-latency memory
// handshake, one-entry stall buffer, redirect draining and HALT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, BUF, DRAIN, HALTED} state_t;

  state_t      state, state_d;
  logic [15:0] req_addr, req_addr_d;
  logic [15:0] next_pc, next_pc_d;
  logic [15:0] instr, instr_d;
  logic [15:0] inc_pc, inc_pc_d;
  logic [15:0] buf_data, buf_data_d;
  logic [15:0] buf_inc, buf_inc_d;
  logic        valid, valid_d;
  logic        halt_pend, halt_pend_d;
  logic        err;
  logic        req_load;
  logic        free, consumed;
  logic [15:0] req_inc;

  assign free     = !valid || !bus.Stall;
  assign consumed = valid && !bus.Stall;
  assign req_inc  = req_addr + 16'd2;

  assign bus.IMemRd     = (state == FETCH) || (state == DRAIN);
  assign bus.IMemAddr   = req_addr;
  assign bus.Instr      = instr;
  assign bus.IncPC      = inc_pc;
  assign bus.InstrValid = valid;
  assign bus.Err        = err;

  always_comb begin
    state_d     = state;
    req_addr_d  = req_addr;
    next_pc_d   = next_pc;
    instr_d     = instr;
    inc_pc_d    = inc_pc;
    buf_data_d  = buf_data;
    buf_inc_d   = buf_inc;
    valid_d     = valid;
    halt_pend_d = halt_pend;
    req_load    = 1'b0;
    case (state)
      FETCH: begin
        if (bus.Redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (bus.IMemDone) begin
            req_addr_d = bus.RedirectPC;
            req_load   = 1'b1;
          end else begin
            next_pc_d   = bus.RedirectPC;
            halt_pend_d = 1'b0;
            state_d     = DRAIN;
          end
        end else if (bus.Halt && consumed) begin
          valid_d     = 1'b0;
          instr_d     = NOP_INSTR;
          halt_pend_d = 1'b1;
          state_d     = bus.IMemDone ? HALTED : DRAIN;
        end else if (bus.IMemDone) begin
          req_addr_d = req_inc;
          req_load   = 1'b1;
          if (free) begin
            instr_d  = bus.IMemData;
            inc_pc_d = req_inc;
            valid_d  = 1'b1;
          end else begin
            buf_data_d = bus.IMemData;
            buf_inc_d  = req_inc;
            state_d    = BUF;
          end
        end else if (consumed) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      BUF: begin
        if (bus.Redirect) begin
          req_addr_d = bus.RedirectPC;
          req_load   = 1'b1;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          state_d    = FETCH;
        end else if (bus.Halt && !bus.Stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = HALTED;
        end else if (!bus.Stall) begin
          instr_d  = buf_data;
          inc_pc_d = buf_inc;
          valid_d  = 1'b1;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (bus.Redirect) begin
          next_pc_d   = bus.RedirectPC;
          halt_pend_d = 1'b0;
        end
        // A redirect arriving with Done cancels a pending halt and wins over NextPC
        if (bus.IMemDone) begin
          if (halt_pend && !bus.Redirect) begin
            state_d = HALTED;
          end else begin
            req_addr_d = bus.Redirect ? bus.RedirectPC : next_pc;
            req_load   = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      req_addr  <= RESET_PC;
      next_pc   <= RESET_PC;
      instr     <= NOP_INSTR;
      inc_pc    <= '0;
      buf_data  <= '0;
      buf_inc   <= '0;
      valid     <= 1'b0;
      halt_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      req_addr  <= req_addr_d;
      next_pc   <= next_pc_d;
      instr     <= instr_d;
      inc_pc    <= inc_pc_d;
      buf_data  <= buf_data_d;
      buf_inc   <= buf_inc_d;
      valid     <= valid_d;
      halt_pend <= halt_pend_d;
      err       <= err | (req_load & req_addr_d[0]);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized episodes, all
// compared against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: output register, pending-delivery queue, discard/halt flags
  logic [15:0] m_pc, m_instr, m_inc, m_target;
  bit          m_valid, m_discard, m_halt_after, m_halted, m_err;
  logic [31:0] m_q[$];

  int unsigned lat, wcnt;
  bit          rnd_lat;
  logic [15:0] mkey;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ mkey;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_inc = '0; m_target = '0;
    m_valid = 0; m_discard = 0; m_halt_after = 0; m_halted = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_set_pc(input logic [15:0] a);
    m_pc = a;
    if (a[0]) m_err = 1;
  endtask

  task automatic model_invalidate();
    m_valid = 0;
    m_instr = NOP;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [15:0] rp,
                            input bit h, input bit d, input logic [15:0] data);
    bit free, consumed;
    logic [31:0] e;
    free     = !m_valid || !s;
    consumed = m_valid && !s;
    if (m_halted) return;
    if (m_discard) begin
      if (r) begin m_target = rp; m_halt_after = 0; end
      if (d) begin
        m_discard = 0;
        if (m_halt_after) m_halted = 1;
        else model_set_pc(m_target);
      end
    end else if (m_q.size() != 0) begin
      if (r) begin m_q.delete(); model_set_pc(rp); model_invalidate(); end
      else if (h && !s) begin m_q.delete(); model_invalidate(); m_halted = 1; end
      else if (!s) begin {m_instr, m_inc} = m_q.pop_front(); m_valid = 1; end
    end else begin
      if (r) begin
        model_invalidate();
        if (d) model_set_pc(rp);
        else begin m_discard = 1; m_target = rp; m_halt_after = 0; end
      end else if (h && consumed) begin
        model_invalidate();
        if (d) m_halted = 1;
        else begin m_discard = 1; m_halt_after = 1; end
      end else if (d) begin
        e = {data, m_pc + 16'd2};
        model_set_pc(m_pc + 16'd2);
        if (free) begin {m_instr, m_inc} = e; m_valid = 1; end
        else m_q.push_back(e);
      end else if (consumed) begin
        model_invalidate();
      end
    end
  endtask

  task automatic check_outputs();
    chk("addr",  bus.IMemAddr, m_pc);
    chk("rd",    16'(bus.IMemRd), 16'(!m_halted && m_q.size() == 0));
    chk("instr", bus.Instr, m_instr);
    chk("incpc", bus.IncPC, m_inc);
    chk("valid", 16'(bus.InstrValid), 16'(m_valid));
    chk("err",   16'(bus.Err), 16'(m_err));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit s, input bit r, input logic [15:0] rp, input bit h);
    bit rd, d;
    logic [15:0] data;
    check_outputs();
    bus.Stall = s; bus.Redirect = r; bus.RedirectPC = rp; bus.Halt = h;
    rd   = bus.IMemRd;
    d    = rd && (wcnt >= lat);
    data = mem_word(bus.IMemAddr);
    bus.IMemDone = d;
    bus.IMemData = data;
    model_step(s, r, rp, h, d, data);
    @(posedge clk);
    if (d) begin
      wcnt = 0;
      if (rnd_lat) lat = $urandom_range(0, 3);
    end else if (rd) begin
      wcnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Stall = 0; bus.Redirect = 0; bus.RedirectPC = '0; bus.Halt = 0;
    bus.IMemDone = 0; bus.IMemData = '0;
    #1;
    chk("rst_instr", bus.Instr, NOP);
    chk("rst_incpc", bus.IncPC, 16'h0000);
    chk("rst_valid", 16'(bus.InstrValid), 16'd0);
    chk("rst_err",   16'(bus.Err), 16'd0);
    chk("rst_rd",    16'(bus.IMemRd), 16'd1);
    chk("rst_addr",  bus.IMemAddr, RST_PC);
    model_reset();
    wcnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mkey = '0; rnd_lat = 0; lat = 0;
    do_reset();

    // Single-cycle memory, data = address
    repeat (3) cycle(0, 0, '0, 0);
    chk("seq_instr", bus.Instr, 16'h0004);
    chk("seq_incpc", bus.IncPC, 16'h0006);

    // Stall while a read completes: buffered, then delivered in order
    cycle(1, 0, '0, 0);
    chk("buf_rd", 16'(bus.IMemRd), 16'd0);
    chk("buf_hold", bus.Instr, 16'h0004);
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("buf_out", bus.Instr, 16'h0006);
    repeat (2) cycle(0, 0, '0, 0);

    // Multi-cycle memory, redirect while read outstanding
    lat = 3;
    cycle(0, 1, 16'h0100, 0);
    chk("drain_valid", 16'(bus.InstrValid), 16'd0);
    repeat (8) cycle(0, 0, '0, 0);

    // Redirect coinciding with Done (wait for a Done cycle first)
    lat = 0;
    for (int i = 0; i < 6 && wcnt != 0; i++) cycle(0, 0, '0, 0);
    repeat (2) cycle(0, 0, '0, 0);
    cycle(0, 1, 16'h0200, 0);
    chk("rdone_valid", 16'(bus.InstrValid), 16'd0);
    chk("rdone_addr", bus.IMemAddr, 16'h0200);

    // Halt with a read outstanding
    lat = 2;
    for (int i = 0; i < 10 && !m_valid; i++) cycle(0, 0, '0, 0);
    chk("halt_setup", 16'(bus.InstrValid), 16'd1);
    cycle(0, 0, '0, 1);
    repeat (4) cycle(0, 0, '0, 0);
    cycle(0, 1, 16'h0040, 0);
    repeat (3) cycle(0, 0, '0, 0);
    chk("halted_rd", 16'(bus.IMemRd), 16'd0);
    chk("halted_instr", bus.Instr, NOP);

    // Odd redirect target sets Err
    do_reset();
    lat = 0;
    cycle(0, 1, 16'h0011, 0);
    chk("odd_addr", bus.IMemAddr, 16'h0011);
    chk("odd_err", 16'(bus.Err), 16'd1);
    repeat (3) cycle(0, 0, '0, 0);

    // Asynchronous reset in the middle of a drain
    do_reset();
    lat = 3;
    cycle(0, 1, 16'h0300, 0);
    cycle(0, 0, '0, 0);
    #2;
    do_reset();
    repeat (4) cycle(0, 0, '0, 0);

    // Randomized episodes, each starting near the 16-bit wrap point
    for (int ep = 0; ep < 6; ep++) begin
      mkey = 16'($urandom);
      do_reset();
      rnd_lat = 1;
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 300; i++) begin
        bit s, r, h;
        logic [15:0] rp;
        s  = ($urandom_range(0, 9) < 3);
        r  = (i == 0) || ($urandom_range(0, 19) == 0);
        rp = (i == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFE);
        h  = ($urandom_range(0, 149) == 0);
        cycle(s, r, rp, h);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
